// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master WISHBONE register-bus arbiter.
package wb_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 22;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Bit positions within the one-hot grant vector.
  localparam int GNT_BM_IDX = 0;
  localparam int GNT_TC_IDX = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_BM = 2'd1,
    GNT_TC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus-timeout watchdog: counts stalled strobe cycles, fires one err pulse,
// kills the strobe until the bus is released and keeps a sticky flag.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic release_bus,
  output logic fire,
  output logic kill,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Fires inside the TIMEOUT_CYCLES-th stalled cycle itself, not one later.
  assign fire = stall && (cnt == LAST_STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      kill    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      // Any non-stalled cycle (idle, grant start, stb low, ack/err) restarts the count.
      if (stall) cnt <= cnt + 1'b1;
      else       cnt <= '0;

      if (release_bus) kill <= 1'b0;
      else if (fire)   kill <= 1'b1;

      if (fire) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter between the boardman (bm) and TURF command (tc) WISHBONE
// masters. Define WB_ARBITER_TIMEOUT_EN to build in the bus-timeout watchdog.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef WB_ARBITER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    bm_cyc_i,
  input  logic                    bm_stb_i,
  input  logic                    bm_we_i,
  input  logic [ADDR_WIDTH-1:0]   bm_adr_i,
  input  logic [DATA_WIDTH-1:0]   bm_dat_i,
  input  logic [DATA_WIDTH/8-1:0] bm_sel_i,
  output logic                    bm_ack_o,
  output logic                    bm_err_o,
  output logic [DATA_WIDTH-1:0]   bm_dat_o,
  input  logic                    tc_cyc_i,
  input  logic                    tc_stb_i,
  input  logic                    tc_we_i,
  input  logic [ADDR_WIDTH-1:0]   tc_adr_i,
  input  logic [DATA_WIDTH-1:0]   tc_dat_i,
  input  logic [DATA_WIDTH/8-1:0] tc_sel_i,
  output logic                    tc_ack_o,
  output logic                    tc_err_o,
  output logic [DATA_WIDTH-1:0]   tc_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [1:0]              gnt_o
`ifdef WB_ARBITER_TIMEOUT_EN
  , output logic                  timeout_o
`endif
);

  arb_state_t state, state_nxt;
  logic       last_tc, last_tc_nxt;
  logic       gnt_bm, gnt_tc;
  logic       stb_sel;
  logic       err_fwd;

  // NOTE: state registers use non-blocking assignments and reset asynchronously,
  // so the slave-side outputs drop the moment wb_rst_ni falls.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      last_tc <= 1'b1;
    end else begin
      state   <= state_nxt;
      last_tc <= last_tc_nxt;
    end
  end

  // NOTE: every combinational output is defaulted first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    last_tc_nxt = last_tc;
    case (state)
      IDLE: begin
        if (bm_cyc_i && (!tc_cyc_i || last_tc)) begin
          state_nxt   = GNT_BM;
          last_tc_nxt = 1'b0;
        end else if (tc_cyc_i) begin
          state_nxt   = GNT_TC;
          last_tc_nxt = 1'b1;
        end
      end
      GNT_BM:  if (!bm_cyc_i) state_nxt = IDLE;
      GNT_TC:  if (!tc_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_bm = (state == GNT_BM);
  assign gnt_tc = (state == GNT_TC);

  assign gnt_o[GNT_BM_IDX] = gnt_bm;
  assign gnt_o[GNT_TC_IDX] = gnt_tc;

  // Request-side mux; everything is zero while no master holds the grant.
  always_comb begin
    s_cyc_o = 1'b0;
    stb_sel = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (gnt_bm) begin
      s_cyc_o = bm_cyc_i;
      stb_sel = bm_stb_i;
      s_we_o  = bm_we_i;
      s_adr_o = bm_adr_i;
      s_dat_o = bm_dat_i;
      s_sel_o = bm_sel_i;
    end else if (gnt_tc) begin
      s_cyc_o = tc_cyc_i;
      stb_sel = tc_stb_i;
      s_we_o  = tc_we_i;
      s_adr_o = tc_adr_i;
      s_dat_o = tc_dat_i;
      s_sel_o = tc_sel_i;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  logic to_fire, to_kill, to_stall;

  assign to_stall = s_cyc_o & stb_sel & ~to_kill & ~s_ack_i & ~s_err_i;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .stall       (to_stall),
    .release_bus (state == IDLE),
    .fire        (to_fire),
    .kill        (to_kill),
    .timeout     (timeout_o)
  );

  assign s_stb_o = stb_sel & ~to_kill;
  assign err_fwd = s_err_i | to_fire;
`else
  assign s_stb_o = stb_sel;
  assign err_fwd = s_err_i;
`endif

  // Responses are steered combinationally to the grant holder only.
  assign bm_ack_o = s_ack_i & gnt_bm;
  assign tc_ack_o = s_ack_i & gnt_tc;
  assign bm_err_o = err_fwd & gnt_bm;
  assign tc_err_o = err_fwd & gnt_tc;
  assign bm_dat_o = s_dat_i;
  assign tc_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter; inputs change 1 ns after
// the rising edge and outputs are sampled 2 ns later, well clear of either edge.
`timescale 1ns/1ps
module tb_wb_master_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bm_cyc, bm_stb, bm_we, tc_cyc, tc_stb, tc_we;
  logic [AW-1:0] bm_adr, tc_adr;
  logic [DW-1:0] bm_wdat, tc_wdat;
  logic [SW-1:0] bm_sel, tc_sel;
  logic          bm_ack_o, bm_err_o, tc_ack_o, tc_err_o;
  logic [DW-1:0] bm_dat_o, tc_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic          s_ack, s_err;
  logic [DW-1:0] s_rdat;
  logic [1:0]    gnt_o;
`ifdef WB_ARBITER_TIMEOUT_EN
  logic          timeout_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
`ifdef WB_ARBITER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bm_cyc_i (bm_cyc),
    .bm_stb_i (bm_stb),
    .bm_we_i  (bm_we),
    .bm_adr_i (bm_adr),
    .bm_dat_i (bm_wdat),
    .bm_sel_i (bm_sel),
    .bm_ack_o (bm_ack_o),
    .bm_err_o (bm_err_o),
    .bm_dat_o (bm_dat_o),
    .tc_cyc_i (tc_cyc),
    .tc_stb_i (tc_stb),
    .tc_we_i  (tc_we),
    .tc_adr_i (tc_adr),
    .tc_dat_i (tc_wdat),
    .tc_sel_i (tc_sel),
    .tc_ack_o (tc_ack_o),
    .tc_err_o (tc_err_o),
    .tc_dat_o (tc_dat_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .s_dat_i  (s_rdat),
    .gnt_o    (gnt_o)
`ifdef WB_ARBITER_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bm_cyc = 0; bm_stb = 0; bm_we = 0; bm_adr = '0; bm_wdat = '0; bm_sel = '0;
    tc_cyc = 0; tc_stb = 0; tc_we = 0; tc_adr = '0; tc_wdat = '0; tc_sel = '0;
    s_ack = 1'b1; s_err = 1'b1; s_rdat = 32'hA5A5_0001;
    #3;
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt actual=%b required=00", gnt_o); end
    checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_s_cyc actual=%b required=0", s_cyc_o); end
    checks++; if (s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_s_stb actual=%b required=0", s_stb_o); end
    checks++; if ({bm_ack_o, tc_ack_o, bm_err_o, tc_err_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_resp actual=%b required=0000", {bm_ack_o, tc_ack_o, bm_err_o, tc_err_o});
    end
    checks++; if (bm_dat_o !== 32'hA5A5_0001) begin failures++; $display("FAIL reset_bm_dat actual=%h required=a5a50001", bm_dat_o); end
`ifdef WB_ARBITER_TIMEOUT_EN
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout actual=%b required=0", timeout_o); end
`endif
    next();
    next();
    rst_n = 1'b1;
  endtask

  task automatic test_spurious_ack();
    next();
    settle();
    checks++; if ({bm_ack_o, tc_ack_o, bm_err_o, tc_err_o} !== 4'b0000) begin
      failures++; $display("FAIL idle_spurious_resp actual=%b required=0000", {bm_ack_o, tc_ack_o, bm_err_o, tc_err_o});
    end
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL idle_gnt actual=%b required=00", gnt_o); end
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_tie();
    next();
    bm_cyc = 1; bm_stb = 1; bm_we = 1; bm_adr = 22'h000010; bm_wdat = 32'h0000_00B0; bm_sel = 4'hF;
    tc_cyc = 1; tc_stb = 1; tc_we = 0; tc_adr = 22'h000020; tc_sel = 4'h3;
    settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL tie_dead_gnt actual=%b required=00", gnt_o); end
    next(); settle();
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL tie_first_gnt actual=%b required=01", gnt_o); end
    checks++; if (s_adr_o !== 22'h000010) begin failures++; $display("FAIL tie_bm_adr actual=%h required=000010", s_adr_o); end
    checks++; if (s_we_o !== 1'b1) begin failures++; $display("FAIL tie_bm_we actual=%b required=1", s_we_o); end
    checks++; if (s_dat_o !== 32'h0000_00B0) begin failures++; $display("FAIL tie_bm_wdat actual=%h required=000000b0", s_dat_o); end
    s_ack = 1; settle();
    checks++; if ({tc_ack_o, bm_ack_o} !== 2'b01) begin failures++; $display("FAIL tie_bm_ack actual=%b required=01", {tc_ack_o, bm_ack_o}); end
    next();
    s_ack = 0; bm_cyc = 0; bm_stb = 0;
    settle();
    checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL tie_release_cyc actual=%b required=0", s_cyc_o); end
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL tie_release_gnt actual=%b required=01", gnt_o); end
    next(); settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL tie_idle_gap actual=%b required=00", gnt_o); end
    next(); settle();
    checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL tie_second_gnt actual=%b required=10", gnt_o); end
    checks++; if (s_adr_o !== 22'h000020) begin failures++; $display("FAIL tie_tc_adr actual=%h required=000020", s_adr_o); end
    checks++; if (s_sel_o !== 4'h3) begin failures++; $display("FAIL tie_tc_sel actual=%h required=3", s_sel_o); end
    s_ack = 1; settle();
    checks++; if ({tc_ack_o, bm_ack_o} !== 2'b10) begin failures++; $display("FAIL tie_tc_ack actual=%b required=10", {tc_ack_o, bm_ack_o}); end
    next();
    s_ack = 0; tc_cyc = 0; tc_stb = 0;
    next(); settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL tie_end_gnt actual=%b required=00", gnt_o); end
  endtask

  task automatic test_round_robin();
    next();
    bm_cyc = 1; bm_stb = 1; bm_we = 0; bm_adr = 22'h000100;
    tc_cyc = 1; tc_stb = 1; tc_we = 0; tc_adr = 22'h000200;
    settle();
    for (int t = 0; t < 8; t++) begin
      logic [1:0]    exp_gnt;
      logic [AW-1:0] exp_adr;
      exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_adr = (t % 2 == 0) ? 22'h000100 : 22'h000200;
      next(); settle();
      checks++; if (gnt_o !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d] actual=%b required=%b", t, gnt_o, exp_gnt); end
      checks++; if (s_adr_o !== exp_adr) begin failures++; $display("FAIL rr_adr[%0d] actual=%h required=%h", t, s_adr_o, exp_adr); end
      s_ack = 1;
      if (exp_gnt == 2'b01) begin bm_cyc = 0; bm_stb = 0; end
      else begin tc_cyc = 0; tc_stb = 0; end
      settle();
      checks++; if ({tc_ack_o, bm_ack_o} !== exp_gnt) begin failures++; $display("FAIL rr_ack[%0d] actual=%b required=%b", t, {tc_ack_o, bm_ack_o}, exp_gnt); end
      next();
      s_ack = 0;
      if (t < 7) begin
        bm_cyc = 1; bm_stb = 1; tc_cyc = 1; tc_stb = 1;
      end else begin
        bm_cyc = 0; bm_stb = 0; tc_cyc = 0; tc_stb = 0;
      end
      settle();
      checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rr_idle[%0d] actual=%b required=00", t, gnt_o); end
    end
  endtask

  task automatic test_single_read();
    next();
    bm_cyc = 1; bm_stb = 1; bm_we = 0; bm_adr = 22'h000004; bm_sel = 4'hF;
    settle();
    checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL read_c0_cyc actual=%b required=0", s_cyc_o); end
    next(); settle();
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL read_c1_gnt actual=%b required=01", gnt_o); end
    checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b110) begin failures++; $display("FAIL read_c1_ctl actual=%b required=110", {s_cyc_o, s_stb_o, s_we_o}); end
    checks++; if (s_adr_o !== 22'h000004) begin failures++; $display("FAIL read_c1_adr actual=%h required=000004", s_adr_o); end
    checks++; if (bm_ack_o !== 1'b0) begin failures++; $display("FAIL read_c1_ack actual=%b required=0", bm_ack_o); end
    next();
    s_ack = 1; s_rdat = 32'h1234_5678;
    settle();
    checks++; if (bm_ack_o !== 1'b1) begin failures++; $display("FAIL read_c2_ack actual=%b required=1", bm_ack_o); end
    checks++; if (bm_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL read_c2_dat actual=%h required=12345678", bm_dat_o); end
    checks++; if (tc_ack_o !== 1'b0) begin failures++; $display("FAIL read_c2_tc_ack actual=%b required=0", tc_ack_o); end
    next();
    s_ack = 0; bm_cyc = 0; bm_stb = 0;
    next(); settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL read_end_gnt actual=%b required=00", gnt_o); end
  endtask

  task automatic test_burst_hold();
    next();
    tc_cyc = 1; tc_stb = 1; tc_we = 0; tc_adr = 22'h000300;
    settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL burst_dead_gnt actual=%b required=00", gnt_o); end
    next();
    bm_cyc = 1; bm_stb = 1; bm_adr = 22'h000400;
    settle();
    for (int b = 0; b < 3; b++) begin
      logic [DW-1:0] exp_dat;
      exp_dat = 32'hB000_0000 + 32'(b);
      s_ack = 1; s_rdat = exp_dat;
      settle();
      checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL burst_gnt[%0d] actual=%b required=10", b, gnt_o); end
      checks++; if ({tc_ack_o, bm_ack_o} !== 2'b10) begin failures++; $display("FAIL burst_ack[%0d] actual=%b required=10", b, {tc_ack_o, bm_ack_o}); end
      checks++; if (tc_dat_o !== exp_dat) begin failures++; $display("FAIL burst_dat[%0d] actual=%h required=%h", b, tc_dat_o, exp_dat); end
      next();
    end
    s_ack = 0; tc_cyc = 0; tc_stb = 0;
    settle();
    checks++; if ({s_cyc_o, gnt_o} !== 3'b010) begin failures++; $display("FAIL burst_release actual=%b required=010", {s_cyc_o, gnt_o}); end
    next(); settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL burst_gap actual=%b required=00", gnt_o); end
    next(); settle();
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL burst_bm_gnt actual=%b required=01", gnt_o); end
    checks++; if (s_adr_o !== 22'h000400) begin failures++; $display("FAIL burst_bm_adr actual=%h required=000400", s_adr_o); end
    next();
    bm_cyc = 0; bm_stb = 0;
    next();
  endtask

  task automatic test_reset_mid();
    next();
    tc_cyc = 1; tc_stb = 1; tc_adr = 22'h000500;
    next(); settle();
    checks++; if ({s_cyc_o, gnt_o} !== 3'b110) begin failures++; $display("FAIL rmid_granted actual=%b required=110", {s_cyc_o, gnt_o}); end
    s_ack = 1;
    rst_n = 0;
    #1;
    checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin failures++; $display("FAIL rmid_slave_drop actual=%b required=00", {s_cyc_o, s_stb_o}); end
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rmid_gnt actual=%b required=00", gnt_o); end
    checks++; if (tc_ack_o !== 1'b0) begin failures++; $display("FAIL rmid_tc_ack actual=%b required=0", tc_ack_o); end
    s_ack = 0; tc_cyc = 0; tc_stb = 0;
    next();
    rst_n = 1;
    next();
    bm_cyc = 1; bm_stb = 1; tc_cyc = 1; tc_stb = 1;
    settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rmid_tie_dead actual=%b required=00", gnt_o); end
    next(); settle();
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL rmid_tie_gnt actual=%b required=01", gnt_o); end
    bm_cyc = 0; bm_stb = 0; tc_cyc = 0; tc_stb = 0;
    next();
    next();
  endtask

`ifdef WB_ARBITER_TIMEOUT_EN
  task automatic test_watchdog();
    next();
    bm_cyc = 1; bm_stb = 1; bm_we = 1; bm_adr = 22'h000600; bm_wdat = 32'hCAFE_F00D;
    settle();
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL wd_dead_gnt actual=%b required=00", gnt_o); end
    for (int k = 1; k <= 16; k++) begin
      logic exp_err;
      exp_err = (k == 16);
      next(); settle();
      checks++; if (bm_err_o !== exp_err) begin failures++; $display("FAIL wd_err[%0d] actual=%b required=%b", k, bm_err_o, exp_err); end
      checks++; if (s_stb_o !== 1'b1) begin failures++; $display("FAIL wd_stb[%0d] actual=%b required=1", k, s_stb_o); end
    end
    next(); settle();
    checks++; if ({s_cyc_o, s_stb_o} !== 2'b10) begin failures++; $display("FAIL wd_kill actual=%b required=10", {s_cyc_o, s_stb_o}); end
    checks++; if (bm_err_o !== 1'b0) begin failures++; $display("FAIL wd_err_once actual=%b required=0", bm_err_o); end
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL wd_sticky actual=%b required=1", timeout_o); end
    bm_cyc = 0; bm_stb = 0; bm_we = 0;
    next();
    tc_cyc = 1; tc_stb = 1; tc_we = 0; tc_adr = 22'h000700;
    next(); settle();
    checks++; if ({gnt_o, s_stb_o} !== 3'b101) begin failures++; $display("FAIL wd_tc_gnt actual=%b required=101", {gnt_o, s_stb_o}); end
    s_ack = 1; settle();
    checks++; if ({tc_ack_o, tc_err_o} !== 2'b10) begin failures++; $display("FAIL wd_tc_resp actual=%b required=10", {tc_ack_o, tc_err_o}); end
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL wd_sticky_hold actual=%b required=1", timeout_o); end
    next();
    s_ack = 0; tc_cyc = 0; tc_stb = 0;
    next();
  endtask
`endif

  initial begin
    test_reset();
    test_spurious_ack();
    test_tie();
    test_round_robin();
    test_single_read();
    test_burst_hold();
    test_reset_mid();
`ifdef WB_ARBITER_TIMEOUT_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master WISHBONE (classic, single-beat) arbiter sharing the 22-bit address / 32-bit data register bus between the serial boardman master (bm_) and the TURF command master (tc_).
- Sits between the two master interfaces and the register slave decoder, all in the regclk (62.5 MHz) domain.
- Grants are round-robin and held for the whole cycle (cyc_o).
- Optional bus-timeout watchdog returns err to a master whose slave never acknowledges.

Parameters:
- ADDR_WIDTH, 22, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- TIMEOUT_CYCLES, 1023, stb cycles without ack/err before the watchdog fires (only with the watchdog compiled in)

Ports:
- wb_clk_i  in  1  bus clock (regclk)
- wb_rst_ni  in  1  asynchronous active-low reset
- bm_cyc_i, bm_stb_i, bm_we_i  in  1 each  master A control
- bm_adr_i  in  ADDR_WIDTH  master A address
- bm_dat_i  in  DATA_WIDTH  master A write data
- bm_sel_i  in  DATA_WIDTH/8  master A byte selects
- bm_ack_o, bm_err_o  out  1 each  master A response
- bm_dat_o  out  DATA_WIDTH  master A read data
- tc_*  same set as bm_*, for master B (TURF command)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side control
- s_adr_o  out  ADDR_WIDTH  slave-side address
- s_dat_o  out  DATA_WIDTH  slave-side write data
- s_sel_o  out  DATA_WIDTH/8  slave-side byte selects
- s_ack_i, s_err_i  in  1 each  slave response
- s_dat_i  in  DATA_WIDTH  slave read data
- gnt_o  out  2  one-hot current grant (bit0 = bm, bit1 = tc), for debug/ILA

Behaviour:
- Interface: one clock (wb_clk_i); wb_rst_ni is asynchronous, active-low.
- Reset values: state IDLE, gnt_o = 0, last_grant = tc, so bm wins the first tie. All s_* control outputs and all ack/err outputs are 0. Read data outputs are don't-care but driven from s_dat_i.
- States:
  - IDLE -> GNT_BM or GNT_TC, on a registered decision.
  - GNT_x -> IDLE when the granted master's cyc_i is low.
- Arbitration (IDLE only):
  - Only bm_cyc_i: grant bm.
  - Only tc_cyc_i: grant tc.
  - Both: grant the master that is NOT last_grant. last_grant updates on every grant.
- Latency: cyc_i seen in IDLE at edge n gives the grant registered at edge n, so s_cyc_o/s_stb_o are visible in cycle n+1. There is one dead cycle per arbitration.
- Granted phase: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are combinational muxes of the granted master, gated by the grant. The non-granted master sees ack = err = 0 and stalls (stb held, per WISHBONE).
- Response routing: s_ack_i/s_err_i are routed only to the granted master, combinationally, so there is zero added latency on the response. s_dat_i fans out to both bm_dat_o and tc_dat_o.
- Grant hold: multiple stb/ack beats while cyc stays high stay within one grant; no preemption. Releasing cyc in the same cycle as ack is legal; the arbiter goes to IDLE next edge.
- Simultaneous release and new request: the decision is still made in IDLE (the dead cycle is kept). Round-robin guarantees tc is served next if it was waiting.
- Spurious slave ack/err in IDLE: ignored, not forwarded.
- Reset mid-cycle: immediate return to IDLE. Slave outputs drop asynchronously, the pending master gets no ack, and last_grant returns to tc.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- With it:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on grant, on any ack/err, and whenever s_stb_o is low.
  - It increments each cycle s_cyc_o & s_stb_o with no ack/err.
  - On reaching TIMEOUT_CYCLES it pulses the granted master's err_o for exactly one cycle, and forces s_stb_o low until the master drops cyc.
  - It sets a sticky timeout_o output (extra 1-bit port, cleared only by reset).
- Without it: no counter, no timeout_o port; a hung slave holds the grant indefinitely.

Decomposition:
- Shared package wb_arb_pkg:
  - state enum (IDLE, GNT_BM, GNT_TC)
  - grant index constants (GNT_BM_IDX = 0, GNT_TC_IDX = 1)
  - default ADDR/DATA widths
- One natural sub-module: wb_arb_timeout (counter + compare + sticky flag), instantiated only under the macro.

Test Plan:
- Single read: bm only, adr 0x000004, slave acks 1 cycle after stb -> s_cyc_o high at cycle 1, bm_ack_o coincident with s_ack_i, bm_dat_o = slave data, gnt_o = 01 then 00.
- Tie after reset: bm and tc assert cyc in the same cycle -> bm granted first; after bm drops cyc, tc granted after one IDLE cycle; tc_ack_o never asserts during the bm grant.
- Round-robin fairness: both request continuously for 8 transactions -> gnt_o alternates 01, 10, 01, ... with exactly one IDLE cycle between grants.
- Burst hold: tc holds cyc for 3 stb/ack beats -> gnt_o stays 10 across all beats and bm stalls throughout.
- Reset mid-transaction: deassert wb_rst_ni while tc is granted and awaiting ack -> s_cyc_o = 0 asynchronously, gnt_o = 00; after release, a bm/tc tie is won by bm.
- Watchdog (macro on, TIMEOUT_CYCLES = 16): bm write, slave never acks -> bm_err_o pulses once in the 16th stall cycle, s_stb_o drops, timeout_o latches 1; a following tc access completes normally.
